// File: rtl/debug_exec_pkg.sv
// Shared encodings for the debug execution controller.
// Commands, controller states and stop causes.
package debug_exec_pkg;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_HALT = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_HOST = 2'd3
    } cause_e;

    function automatic int bp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_exec_ctrl_bp_match.sv
// Breakpoint slot register file with PC compare.
// Reports the lowest enabled slot whose address equals the PC.
module debug_bp_match
    import debug_exec_pkg::*;
#(
    parameter int BITS_SIZE = 32,
    parameter int NUM_BP    = 4,
    parameter int BP_IDX    = bp_idx_w(NUM_BP)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 wr_en,
    input  logic [BP_IDX-1:0]    wr_index,
    input  logic [BITS_SIZE-1:0] wr_addr,
    input  logic                 wr_enable,
    input  logic [BITS_SIZE-1:0] pc,
    output logic                 match,
    output logic [BP_IDX-1:0]    hit_index
);

    logic [BITS_SIZE-1:0] addr_q [NUM_BP];
    logic [NUM_BP-1:0]    en_q;
    logic                 wr_ok;

    // Indices past the last slot exist when NUM_BP is not a power of two.
    assign wr_ok = wr_en && (32'(wr_index) < 32'(NUM_BP));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= '0;
            end
            en_q <= '0;
        end else if (wr_ok) begin
            addr_q[wr_index] <= wr_addr;
            en_q[wr_index]   <= wr_enable;
        end
    end

    // Scan downward so the lowest matching slot wins.
    always_comb begin
        match     = 1'b0;
        hit_index = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (en_q[i] && (addr_q[i] == pc)) begin
                match     = 1'b1;
                hit_index = BP_IDX'(i);
            end
        end
    end

endmodule

// File: rtl/debug_exec_ctrl.sv
// MIPS execution controller: run, step and run-to-breakpoint.
// Owns the MIPS clock-enable and the enabled-cycle counter.
module debug_exec_ctrl
    import debug_exec_pkg::*;
#(
    parameter int BITS_SIZE = 32,
    parameter int CNT_SIZE  = 32,
    parameter int STEP_SIZE = 16,
    parameter int NUM_BP    = 4,
    parameter int BP_IDX    = bp_idx_w(NUM_BP)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    input  logic [STEP_SIZE-1:0] i_step_count,
    input  logic                 i_bp_wr_en,
    input  logic [BP_IDX-1:0]    i_bp_index,
    input  logic [BITS_SIZE-1:0] i_bp_addr,
    input  logic                 i_bp_enable,
    input  logic [BITS_SIZE-1:0] i_mips_pc,
    input  logic                 i_halt,
    output logic                 o_ctl_clk_wiz,
    output logic [CNT_SIZE-1:0]  o_cycle_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_stop_cause,
    output logic [BP_IDX-1:0]    o_bp_hit_index,
    output logic [1:0]           o_state
);

    state_e               state_q, state_d;
    cause_e               cause_q, cause_d;
    logic                 first_q, first_d;
    logic [STEP_SIZE-1:0] rem_q, rem_d;
    logic [BP_IDX-1:0]    hit_q, hit_d;
    logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
    logic                 done_q;

    logic                 bp_match;
    logic [BP_IDX-1:0]    bp_index;
    cmd_e                 cmd;
    logic                 run_st;
    logic                 step_st;
    logic                 busy;
    logic                 stop_cmd;
    logic                 halt_stop;
    logic                 bp_stop;
    logic                 clk_en;

    debug_bp_match #(
        .BITS_SIZE (BITS_SIZE),
        .NUM_BP    (NUM_BP),
        .BP_IDX    (BP_IDX)
    ) u_bp_match (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .wr_en     (i_bp_wr_en),
        .wr_index  (i_bp_index),
        .wr_addr   (i_bp_addr),
        .wr_enable (i_bp_enable),
        .pc        (i_mips_pc),
        .match     (bp_match),
        .hit_index (bp_index)
    );

    assign cmd       = cmd_e'(i_cmd);
    assign run_st    = (state_q == ST_RUN);
    assign step_st   = (state_q == ST_STEP);
    assign busy      = run_st || step_st;
    assign stop_cmd  = i_cmd_valid && (cmd == CMD_STOP);
    assign halt_stop = busy && i_halt;

    // The first RUN cycle ignores breakpoints so a resume can leave one.
    assign bp_stop = run_st && !first_q && bp_match && !halt_stop;

    assign clk_en =
        (run_st && !halt_stop && !bp_stop && !stop_cmd) ||
        (step_st && !halt_stop && !stop_cmd);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        first_d = first_q;
        rem_d   = rem_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;

        if (clk_en && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_SIZE'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_cmd_valid) begin
                    unique case (cmd)
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            first_d = 1'b1;
                            cause_d = CAUSE_NONE;
                            hit_d   = '0;
                        end
                        CMD_STEP: begin
                            state_d = ST_STEP;
                            cause_d = CAUSE_NONE;
                            rem_d   = (i_step_count == '0) ?
                                      STEP_SIZE'(1) : i_step_count;
                        end
                        CMD_CLEAR: begin
                            state_d = ST_IDLE;
                            cause_d = CAUSE_NONE;
                            hit_d   = '0;
                            cnt_d   = '0;
                        end
                        CMD_STOP: begin
                        end
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                first_d = 1'b0;
                if (halt_stop) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (bp_stop) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BP;
                    hit_d   = bp_index;
                end else if (stop_cmd) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HOST;
                end else if (step_st && clk_en) begin
                    rem_d = rem_q - STEP_SIZE'(1);
                    if (rem_q == STEP_SIZE'(1)) begin
                        state_d = ST_DONE;
                        cause_d = CAUSE_HOST;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            first_q <= 1'b0;
            rem_q   <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            first_q <= first_d;
            rem_q   <= rem_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign o_ctl_clk_wiz  = clk_en;
    assign o_cycle_count  = cnt_q;
    assign o_busy         = busy;
    assign o_done         = done_q;
    assign o_stop_cause   = cause_q;
    assign o_bp_hit_index = hit_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Bench for debug_exec_ctrl: vector table plus hand sequences,
// with a second instance at CNT_SIZE=4 for counter saturation.
module tb_debug_exec_ctrl;
    import debug_exec_pkg::*;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [1:0]  cmd;
        logic [15:0] sc;
        logic        halt;
        logic [31:0] pc;
        logic        en;
        logic [1:0]  st;
        logic        done;
        logic [1:0]  cause;
        logic [31:0] cnt;
        logic [1:0]  hit;
    } vec_t;

    logic        wire_clk_wz = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'd0;
    logic [15:0] i_step_count = '0;
    logic        i_bp_wr_en = 1'b0;
    logic [1:0]  i_bp_index = '0;
    logic [31:0] i_bp_addr = '0;
    logic        i_bp_enable = 1'b0;
    logic [31:0] i_mips_pc = '0;
    logic        i_halt = 1'b0;

    logic        en1, busy1, done1;
    logic [31:0] cnt1;
    logic [1:0]  cause1, hit1, st1;
    logic        en2, busy2, done2;
    logic [3:0]  cnt2;
    logic [1:0]  cause2, hit2, st2;

    int   nerr = 0;
    int   nchk = 0;
    int   vid  = 0;
    logic en_pre1, en_pre2;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 wire_clk_wz = ~wire_clk_wz;

    debug_exec_ctrl dut (
        .i_clk          (wire_clk_wz),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .i_step_count   (i_step_count),
        .i_bp_wr_en     (i_bp_wr_en),
        .i_bp_index     (i_bp_index),
        .i_bp_addr      (i_bp_addr),
        .i_bp_enable    (i_bp_enable),
        .i_mips_pc      (i_mips_pc),
        .i_halt         (i_halt),
        .o_ctl_clk_wiz  (en1),
        .o_cycle_count  (cnt1),
        .o_busy         (busy1),
        .o_done         (done1),
        .o_stop_cause   (cause1),
        .o_bp_hit_index (hit1),
        .o_state        (st1)
    );

    debug_exec_ctrl #(.CNT_SIZE(4)) dut4 (
        .i_clk          (wire_clk_wz),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .i_step_count   (i_step_count),
        .i_bp_wr_en     (i_bp_wr_en),
        .i_bp_index     (i_bp_index),
        .i_bp_addr      (i_bp_addr),
        .i_bp_enable    (i_bp_enable),
        .i_mips_pc      (i_mips_pc),
        .i_halt         (i_halt),
        .o_ctl_clk_wiz  (en2),
        .o_cycle_count  (cnt2),
        .o_busy         (busy2),
        .o_done         (done2),
        .o_stop_cause   (cause2),
        .o_bp_hit_index (hit2),
        .o_state        (st2)
    );

    function automatic vec_t mk(
        input logic rst, input logic cv, input logic [1:0] cmd,
        input logic [15:0] sc, input logic halt, input logic [31:0] pc,
        input logic en, input logic [1:0] st, input logic done,
        input logic [1:0] cause, input logic [31:0] cnt,
        input logic [1:0] hit);
        vec_t v;
        v.rst = rst;   v.cv = cv;     v.cmd = cmd;     v.sc = sc;
        v.halt = halt; v.pc = pc;     v.en = en;       v.st = st;
        v.done = done; v.cause = cause; v.cnt = cnt;   v.hit = hit;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec %0d: got %0h expected %0h",
                     name, vid, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        logic [31:0] exp4;
        @(negedge wire_clk_wz);
        i_reset      = v.rst;
        i_cmd_valid  = v.cv;
        i_cmd        = v.cmd;
        i_step_count = v.sc;
        i_halt       = v.halt;
        i_mips_pc    = v.pc;
        sb.push_back(v);
        #1;
        en_pre1 = en1;
        en_pre2 = en2;
        @(posedge wire_clk_wz);
        #1;
        i_cmd_valid = 1'b0;
        e = sb.pop_front();
        exp4 = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
        chk("clk_en", en_pre1, e.en);
        chk("state", st1, e.st);
        chk("busy", busy1, (e.st == ST_RUN) || (e.st == ST_STEP));
        chk("done", done1, e.done);
        chk("cause", cause1, e.cause);
        chk("count", cnt1, e.cnt);
        chk("hit", hit1, e.hit);
        chk("clk_en4", en_pre2, e.en);
        chk("state4", st2, e.st);
        chk("busy4", busy2, busy1);
        chk("done4", done2, e.done);
        chk("cause4", cause2, e.cause);
        chk("hit4", hit2, e.hit);
        chk("count4", cnt2, exp4);
        vid++;
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [31:0] a,
                            input logic en);
        @(negedge wire_clk_wz);
        i_bp_wr_en  = 1'b1;
        i_bp_index  = idx;
        i_bp_addr   = a;
        i_bp_enable = en;
        @(posedge wire_clk_wz);
        #1;
        i_bp_wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // STEP 5: enable high exactly five cycles, then DONE/HOST.
        tbl.push_back(mk(0,1,CMD_STEP,5,0,0, 0,ST_STEP,0,CAUSE_NONE,0,0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0,0,0,0,0,0, 1,ST_STEP,0,CAUSE_NONE,i,0));
        tbl.push_back(mk(0,0,0,0,0,0, 1,ST_DONE,1,CAUSE_HOST,5,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,ST_DONE,0,CAUSE_HOST,5,0));
        tbl.push_back(mk(0,1,CMD_CLEAR,0,0,0, 0,ST_IDLE,0,CAUSE_NONE,0,0));
        // RUN with PC ramp into breakpoints at 0x20 (slots 0 and 2).
        tbl.push_back(mk(0,1,CMD_RUN,0,0,0, 0,ST_RUN,0,CAUSE_NONE,0,0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0,0,0,0,0,32'(4*k),
                             1,ST_RUN,0,CAUSE_NONE,32'(k+1),0));
        tbl.push_back(mk(0,0,0,0,0,32'h20, 0,ST_DONE,1,CAUSE_BP,8,0));

        repeat (2) @(posedge wire_clk_wz);
        apply(mk(0,0,0,0,0,0, 0,ST_IDLE,0,CAUSE_NONE,0,0));
        bp_write(2'd0, 32'h20, 1'b1);
        bp_write(2'd2, 32'h20, 1'b1);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Resume from the breakpoint PC: first cycle is clocked.
        apply(mk(0,1,CMD_RUN,0,0,32'h20, 0,ST_RUN,0,CAUSE_NONE,8,0));
        apply(mk(0,0,0,0,0,32'h20, 1,ST_RUN,0,CAUSE_NONE,9,0));
        apply(mk(0,0,0,0,0,32'h24, 1,ST_RUN,0,CAUSE_NONE,10,0));
        // Halt at a breakpoint PC wins over the breakpoint.
        apply(mk(0,0,0,0,1,32'h20, 0,ST_DONE,1,CAUSE_HALT,10,0));

        // RUN ten cycles, STOP, CLEAR.
        apply(mk(0,1,CMD_CLEAR,0,0,32'h20, 0,ST_IDLE,0,CAUSE_NONE,0,0));
        apply(mk(0,1,CMD_RUN,0,0,32'h100, 0,ST_RUN,0,CAUSE_NONE,0,0));
        for (int k = 0; k < 10; k++)
            apply(mk(0,0,0,0,0,32'h100+32'(4*k),
                     1,ST_RUN,0,CAUSE_NONE,32'(k+1),0));
        apply(mk(0,1,CMD_STOP,0,0,32'h128, 0,ST_DONE,1,CAUSE_HOST,10,0));
        apply(mk(0,1,CMD_CLEAR,0,0,32'h128, 0,ST_IDLE,0,CAUSE_NONE,0,0));

        // Twenty cycles: 4-bit instance saturates at 15.
        apply(mk(0,1,CMD_RUN,0,0,32'h200, 0,ST_RUN,0,CAUSE_NONE,0,0));
        for (int k = 0; k < 20; k++)
            apply(mk(0,0,0,0,0,32'h200+32'(4*k),
                     1,ST_RUN,0,CAUSE_NONE,32'(k+1),0));
        apply(mk(0,1,CMD_STOP,0,0,32'h300, 0,ST_DONE,1,CAUSE_HOST,20,0));
        apply(mk(0,0,0,0,0,32'h300, 0,ST_DONE,0,CAUSE_HOST,20,0));

        // STEP with count 0 behaves as a single step.
        apply(mk(0,1,CMD_STEP,0,0,32'h300, 0,ST_STEP,0,CAUSE_NONE,20,0));
        apply(mk(0,0,0,0,0,32'h300, 1,ST_DONE,1,CAUSE_HOST,21,0));

        // Reset mid-STEP: aborts with no done pulse.
        apply(mk(0,1,CMD_STEP,10,0,32'h300, 0,ST_STEP,0,CAUSE_NONE,21,0));
        for (int i = 0; i < 3; i++)
            apply(mk(0,0,0,0,0,32'h300,
                     1,ST_STEP,0,CAUSE_NONE,32'(22+i),0));
        apply(mk(1,0,0,0,0,32'h300, 1,ST_IDLE,0,CAUSE_NONE,0,0));
        apply(mk(0,0,0,0,0,32'h300, 0,ST_IDLE,0,CAUSE_NONE,0,0));

        // Reset cleared the breakpoint table: 0x20 no longer stops.
        apply(mk(0,1,CMD_RUN,0,0,32'h20, 0,ST_RUN,0,CAUSE_NONE,0,0));
        apply(mk(0,0,0,0,0,32'h20, 1,ST_RUN,0,CAUSE_NONE,1,0));
        apply(mk(0,0,0,0,0,32'h20, 1,ST_RUN,0,CAUSE_NONE,2,0));
        apply(mk(0,1,CMD_STOP,0,0,32'h20, 0,ST_DONE,1,CAUSE_HOST,2,0));

        // Highest slot alone reports its own index, held in DONE.
        bp_write(2'd3, 32'h40, 1'b1);
        apply(mk(0,1,CMD_RUN,0,0,32'h3c, 0,ST_RUN,0,CAUSE_NONE,2,0));
        apply(mk(0,0,0,0,0,32'h3c, 1,ST_RUN,0,CAUSE_NONE,3,0));
        apply(mk(0,0,0,0,0,32'h40, 0,ST_DONE,1,CAUSE_BP,3,3));
        apply(mk(0,0,0,0,0,32'h40, 0,ST_DONE,0,CAUSE_BP,3,3));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
